// File: rtl/parking_pkg.sv
// Shared types, codes and helpers for the parking elevator scheduler.
// Imported by the scheduler top and its request FIFO.
package parking_pkg;

    localparam int FLOOR_W = 3;
    localparam int PLATE_W = 16;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_DROPPED = 2'd1;
    localparam logic [1:0] ST_ABORTED = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_TO_PICKUP = 2'd1,
        S_TO_DEST   = 2'd2
    } state_t;

    typedef struct packed {
        logic [PLATE_W-1:0] plate;
        logic [FLOOR_W-1:0] floor;
    } req_t;

    // Bit f set for every serviceable parking floor 1..top.
    function automatic logic [(1<<FLOOR_W)-1:0] floor_range(input int top);
        logic [(1<<FLOOR_W)-1:0] m;
        m = '0;
        for (int f = 1; f < (1 << FLOOR_W); f++)
            if (f <= top) m[f] = 1'b1;
        return m;
    endfunction

    function automatic logic [FLOOR_W-1:0] step_toward(
        input logic [FLOOR_W-1:0] cur,
        input logic [FLOOR_W-1:0] tgt
    );
        return (tgt > cur) ? cur + FLOOR_W'(1) : cur - FLOOR_W'(1);
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// Small synchronous request FIFO with registered occupancy count.
// Pushes to a full queue and pops from an empty one are ignored.
module sched_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/parking_elevator_scheduler.sv
// Parking elevator scheduler: queues IN/OUT requests, arbitrates round-robin
// and drives the car one floor per cycle through pickup and delivery.
module parking_elevator_scheduler
    import parking_pkg::*;
#(
    parameter int QDEPTH    = 4,
    parameter int TOP_FLOOR = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_dir,
    input  logic [PLATE_W-1:0] req_plate,
    input  logic [FLOOR_W-1:0] req_floor,
    input  logic               leakage,
    input  logic [FLOOR_W-1:0] leakage_floor,
    output logic [FLOOR_W-1:0] current_floor,
    output logic [PLATE_W-1:0] moving,
    output logic               busy,
    output logic               done_valid,
    output logic [PLATE_W-1:0] done_plate,
    output logic               done_dir,
    output logic [1:0]         done_status,
    output logic [7:0]         leak_mask
);
    localparam int         REQ_W    = PLATE_W + FLOOR_W;
    localparam logic [7:0] FLOOR_OK = floor_range(TOP_FLOOR);

    state_t             state;
    logic               last_served;
    logic [PLATE_W-1:0] cur_plate;
    logic               cur_dir;
    logic [FLOOR_W-1:0] cur_floor;
    logic [FLOOR_W-1:0] pickup;
    logic [FLOOR_W-1:0] dest;
    logic               abort;

    req_t req_in;
    req_t in_head;
    req_t out_head;
    req_t head;
    logic in_full, in_empty, out_full, out_empty;
    logic in_push, out_push, in_pop, out_pop;
    logic dispatch, take_out, head_dir, head_drop, abort_hit;

    assign req_in    = '{plate: req_plate, floor: req_floor};
    assign req_ready = (req_dir == DIR_OUT) ? !out_full : !in_full;
    assign in_push   = req_valid && (req_dir == DIR_IN) && !in_full;
    assign out_push  = req_valid && (req_dir == DIR_OUT) && !out_full;

    // With both queues pending, the one not served last wins.
    assign take_out  = !out_empty && (in_empty || last_served == DIR_IN);
    assign dispatch  = (state == S_IDLE) && !(in_empty && out_empty);
    assign in_pop    = dispatch && !take_out;
    assign out_pop   = dispatch && take_out;
    assign head      = take_out ? out_head : in_head;
    assign head_dir  = take_out ? DIR_OUT : DIR_IN;
    assign head_drop = !FLOOR_OK[head.floor] || leak_mask[head.floor];
    assign busy      = (state != S_IDLE);

    // A finishing unload is never turned into an abort.
    assign abort_hit = (state != S_IDLE) && (cur_dir == DIR_IN) && !abort
                    && !(state == S_TO_DEST && current_floor == dest)
                    && (leak_mask[cur_floor]
                        || (leakage && leakage_floor == cur_floor));

    sched_fifo #(.WIDTH(REQ_W), .DEPTH(QDEPTH)) u_in_q (
        .clock (clock),
        .reset (reset),
        .push  (in_push),
        .pop   (in_pop),
        .din   (req_in),
        .dout  (in_head),
        .full  (in_full),
        .empty (in_empty)
    );

    sched_fifo #(.WIDTH(REQ_W), .DEPTH(QDEPTH)) u_out_q (
        .clock (clock),
        .reset (reset),
        .push  (out_push),
        .pop   (out_pop),
        .din   (req_in),
        .dout  (out_head),
        .full  (out_full),
        .empty (out_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            last_served   <= DIR_OUT;
            current_floor <= '0;
            moving        <= '0;
            cur_plate     <= '0;
            cur_dir       <= DIR_IN;
            cur_floor     <= '0;
            pickup        <= '0;
            dest          <= '0;
            abort         <= 1'b0;
            done_valid    <= 1'b0;
            done_plate    <= '0;
            done_dir      <= 1'b0;
            done_status   <= ST_OK;
            leak_mask     <= '0;
        end else begin
            done_valid <= 1'b0;
            if (leakage && FLOOR_OK[leakage_floor])
                leak_mask[leakage_floor] <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (dispatch) begin
                        last_served <= head_dir;
                        if (head_drop) begin
                            done_valid  <= 1'b1;
                            done_plate  <= head.plate;
                            done_dir    <= head_dir;
                            done_status <= ST_DROPPED;
                        end else begin
                            cur_plate <= head.plate;
                            cur_dir   <= head_dir;
                            cur_floor <= head.floor;
                            pickup    <= (head_dir == DIR_IN) ? '0 : head.floor;
                            dest      <= (head_dir == DIR_IN) ? head.floor : '0;
                            abort     <= 1'b0;
                            state     <= S_TO_PICKUP;
                        end
                    end
                end
                S_TO_PICKUP: begin
                    if (current_floor != pickup) begin
                        current_floor <= step_toward(current_floor, pickup);
                    end else begin
                        moving <= cur_plate;
                        state  <= S_TO_DEST;
                    end
                end
                S_TO_DEST: begin
                    if (current_floor != dest) begin
                        current_floor <= step_toward(current_floor, dest);
                    end else begin
                        moving      <= '0;
                        done_valid  <= 1'b1;
                        done_plate  <= cur_plate;
                        done_dir    <= cur_dir;
                        done_status <= abort ? ST_ABORTED : ST_OK;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (abort_hit) begin
                abort <= 1'b1;
                dest  <= '0;
            end
        end
    end

endmodule
